// File: rtl/wired_cdb_arbiter_if.sv
// CDB payload type and the writeback bus bundle between the four result
// sources and the two-port CDB arbiter.
package wired_cdb_pkg;
    typedef struct packed {
        logic        valid;
        logic [5:0]  wid;
        logic [31:0] data;
        logic        exc;
    } pipeline_cdb_t;
endpackage

interface wired_cdb_arbiter_if;
    wired_cdb_pkg::pipeline_cdb_t       alu0_cdb_i;
    wired_cdb_pkg::pipeline_cdb_t       alu1_cdb_i;
    wired_cdb_pkg::pipeline_cdb_t       lsu_cdb_i;
    wired_cdb_pkg::pipeline_cdb_t       mdu_cdb_i;
    logic                               alu0_ready_o;
    logic                               alu1_ready_o;
    logic                               lsu_ready_o;
    logic                               mdu_ready_o;
    wired_cdb_pkg::pipeline_cdb_t [1:0] cdb_o;

    // Source side: drives results, sees grants and the registered CDB.
    modport master (
        output alu0_cdb_i, alu1_cdb_i, lsu_cdb_i, mdu_cdb_i,
        input  alu0_ready_o, alu1_ready_o, lsu_ready_o, mdu_ready_o,
        input  cdb_o
    );

    modport slave (
        input  alu0_cdb_i, alu1_cdb_i, lsu_cdb_i, mdu_cdb_i,
        output alu0_ready_o, alu1_ready_o, lsu_ready_o, mdu_ready_o,
        output cdb_o
    );
endinterface

// File: rtl/wired_cdb_arbiter.sv
// Two-port CDB arbiter: each ROB bank (wid[0]) gets one fixed-priority grant
// per cycle, with starvation promotion for LSU and MDU; CDB output registered.
module wired_cdb_arbiter
    import wired_cdb_pkg::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush_i,
    wired_cdb_arbiter_if.slave cdb_bus
);
    localparam int NSRC     = 4;
    localparam int NBANK    = 2;
    localparam int SRC_ALU0 = 0;
    localparam int SRC_ALU1 = 1;
    localparam int SRC_LSU  = 2;
    localparam int SRC_MDU  = 3;
    localparam int CNT_W    = $clog2(STARVE_LIMIT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

    pipeline_cdb_t    src_cdb [NSRC];
    logic [NSRC-1:0]  src_req;
    logic [NSRC-1:0]  src_bank;
    logic [NSRC-1:0]  src_gnt;
    logic             arb_en;
    logic             lsu_starve;
    logic             mdu_starve;
    logic [CNT_W-1:0] lsu_cnt_reg;
    logic [CNT_W-1:0] lsu_cnt_next;
    logic [CNT_W-1:0] mdu_cnt_reg;
    logic [CNT_W-1:0] mdu_cnt_next;

    assign src_cdb[SRC_ALU0] = cdb_bus.alu0_cdb_i;
    assign src_cdb[SRC_ALU1] = cdb_bus.alu1_cdb_i;
    assign src_cdb[SRC_LSU]  = cdb_bus.lsu_cdb_i;
    assign src_cdb[SRC_MDU]  = cdb_bus.mdu_cdb_i;

    // Reset and flush suppress every request, so no source can pop.
    assign arb_en = !rst && !flush_i;

    genvar gi;
    generate
        for (gi = 0; gi < NSRC; gi++) begin : g_src
            assign src_req[gi]  = src_cdb[gi].valid && arb_en;
            assign src_bank[gi] = src_cdb[gi].wid[0];
        end
    endgenerate

    assign lsu_starve = (lsu_cnt_reg == CNT_MAX);
    assign mdu_starve = (mdu_cnt_reg == CNT_MAX);

    generate
        for (gi = 0; gi < NBANK; gi++) begin : g_bank
            logic [NSRC-1:0] cand;
            logic [NSRC-1:0] gnt;
            pipeline_cdb_t   pick;
            pipeline_cdb_t   slot_reg;

            assign cand = src_req & ((gi == 1) ? src_bank : ~src_bank);

            always_comb begin
                gnt = '0;
                if (cand[SRC_LSU] && lsu_starve) begin
                    gnt[SRC_LSU] = 1'b1;
                end else if (cand[SRC_MDU] && mdu_starve) begin
                    gnt[SRC_MDU] = 1'b1;
                end else if (cand[SRC_ALU0]) begin
                    gnt[SRC_ALU0] = 1'b1;
                end else if (cand[SRC_ALU1]) begin
                    gnt[SRC_ALU1] = 1'b1;
                end else if (cand[SRC_LSU]) begin
                    gnt[SRC_LSU] = 1'b1;
                end else if (cand[SRC_MDU]) begin
                    gnt[SRC_MDU] = 1'b1;
                end
            end

            always_comb begin
                pick = '0;
                for (int s = 0; s < NSRC; s++) begin
                    if (gnt[s]) begin
                        pick = src_cdb[s];
                    end
                end
            end

            // Payload only loads on a grant so an empty slot holds its last value.
            always_ff @(posedge clk) begin
                if (rst) begin
                    slot_reg <= '0;
                end else if (|gnt) begin
                    slot_reg       <= pick;
                    slot_reg.valid <= 1'b1;
                end else begin
                    slot_reg.valid <= 1'b0;
                end
            end
        end
    endgenerate

    // Each source is a candidate on exactly one bank, so OR-ing is safe.
    assign src_gnt = g_bank[0].gnt | g_bank[1].gnt;

    assign cdb_bus.alu0_ready_o = src_gnt[SRC_ALU0];
    assign cdb_bus.alu1_ready_o = src_gnt[SRC_ALU1];
    assign cdb_bus.lsu_ready_o  = src_gnt[SRC_LSU];
    assign cdb_bus.mdu_ready_o  = src_gnt[SRC_MDU];
    assign cdb_bus.cdb_o        = {g_bank[1].slot_reg, g_bank[0].slot_reg};

    function automatic logic [CNT_W-1:0] starve_step(
        input logic [CNT_W-1:0] cnt,
        input logic             valid,
        input logic             granted,
        input logic             flush
    );
        logic [CNT_W-1:0] nxt;
        nxt = cnt;
        if (flush || !valid || granted) begin
            nxt = '0;
        end else if (cnt != CNT_MAX) begin
            nxt = cnt + CNT_W'(1);
        end
        return nxt;
    endfunction

    assign lsu_cnt_next = starve_step(lsu_cnt_reg, src_cdb[SRC_LSU].valid,
                                      src_gnt[SRC_LSU], flush_i);
    assign mdu_cnt_next = starve_step(mdu_cnt_reg, src_cdb[SRC_MDU].valid,
                                      src_gnt[SRC_MDU], flush_i);

    always_ff @(posedge clk) begin
        if (rst) begin
            lsu_cnt_reg <= '0;
            mdu_cnt_reg <= '0;
        end else begin
            lsu_cnt_reg <= lsu_cnt_next;
            mdu_cnt_reg <= mdu_cnt_next;
        end
    end
endmodule

// File: tb/tb_wired_cdb_arbiter.sv
// Directed bench for wired_cdb_arbiter: expected CDB slots are queued when a
// cycle is driven and compared one edge later; ready and counters checked inline.
module tb_wired_cdb_arbiter;
    import wired_cdb_pkg::*;

    localparam int unsigned LIMIT = 4;

    typedef struct packed {
        logic          full;
        pipeline_cdb_t v;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic flush_i;
    int   pass_cnt = 0;
    int   total    = 0;
    exp_t q0[$];
    exp_t q1[$];

    always #5 clk = ~clk;

    wired_cdb_arbiter_if bus ();

    wired_cdb_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk     (clk),
        .rst     (rst),
        .flush_i (flush_i),
        .cdb_bus (bus)
    );

    function automatic pipeline_cdb_t mk(input logic [5:0] w, input logic [31:0] d);
        pipeline_cdb_t r;
        r.valid = 1'b1;
        r.wid   = w;
        r.data  = d;
        r.exc   = d[0];
        return r;
    endfunction

    function automatic exp_t ev(input pipeline_cdb_t p);
        exp_t e;
        e.full = 1'b1;
        e.v    = p;
        return e;
    endfunction

    // Empty slot whose payload must still be the held value p.
    function automatic exp_t eh(input pipeline_cdb_t p);
        exp_t e;
        e.full    = 1'b1;
        e.v       = p;
        e.v.valid = 1'b0;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic drive(input pipeline_cdb_t a0, input pipeline_cdb_t a1,
                         input pipeline_cdb_t ls, input pipeline_cdb_t md);
        bus.alu0_cdb_i = a0;
        bus.alu1_cdb_i = a1;
        bus.lsu_cdb_i  = ls;
        bus.mdu_cdb_i  = md;
    endtask

    task automatic pop_chk(input int k, input string tag);
        exp_t          e;
        pipeline_cdb_t obs;
        obs = bus.cdb_o[k];
        if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
            total++;
            $error("FAIL %s cdb%0d: observed empty scoreboard, expected an entry", tag, k);
            return;
        end
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        if (e.full) chk($sformatf("%s cdb%0d", tag, k), 64'(obs), 64'(e.v));
        else        chk($sformatf("%s cdb%0d.valid", tag, k), 64'(obs.valid), 64'(e.v.valid));
    endtask

    // One clock cycle: check same-cycle ready, queue the slots due next cycle.
    task automatic step(input string tag, input logic [3:0] exp_rdy, input exp_t e0, input exp_t e1);
        #1;
        chk({tag, " ready"},
            64'({bus.mdu_ready_o, bus.lsu_ready_o, bus.alu1_ready_o, bus.alu0_ready_o}),
            64'(exp_rdy));
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1;
        pop_chk(0, tag);
        pop_chk(1, tag);
    endtask

    initial begin
        pipeline_cdb_t z, a0, a1, ls, md, p, p4, a0pre, a0new, ls5, a1j;
        z = '0;

        // Reset, idle
        rst = 1'b1; flush_i = 1'b0;
        drive(z, z, z, z);
        step("rst0", 4'b0000, ev(z), ev(z));
        step("rst1", 4'b0000, ev(z), ev(z));
        chk("rst lsu_cnt", 64'(dut.lsu_cnt_reg), 64'(0));
        chk("rst mdu_cnt", 64'(dut.mdu_cnt_reg), 64'(0));
        rst = 1'b0;
        step("idle0", 4'b0000, ev(z), ev(z));
        step("idle1", 4'b0000, ev(z), ev(z));

        // Bank split
        a0 = mk(6'd6, 32'h1111_0006);
        ls = mk(6'd9, 32'h2222_0009);
        drive(a0, z, ls, z);
        step("split", 4'b0101, ev(a0), ev(ls));
        drive(z, z, z, z);
        step("split hold", 4'b0000, eh(a0), eh(ls));

        // Same-bank conflict
        a0 = mk(6'd4, 32'h3333_0004);
        a1 = mk(6'd2, 32'h4444_0002);
        md = mk(6'd8, 32'h5555_0008);
        drive(a0, a1, z, md);
        step("conf t0", 4'b0001, ev(a0), eh(ls));
        chk("conf mdu_cnt1", 64'(dut.mdu_cnt_reg), 64'(1));
        drive(z, a1, z, md);
        step("conf t1", 4'b0010, ev(a1), eh(ls));
        chk("conf mdu_cnt2", 64'(dut.mdu_cnt_reg), 64'(2));
        drive(z, z, z, md);
        step("conf t2", 4'b1000, ev(md), eh(ls));
        chk("conf mdu_cnt0", 64'(dut.mdu_cnt_reg), 64'(0));

        // Starvation: ALU0/ALU1 alternate on bank 0, LSU waits
        ls = mk(6'd0, 32'h6666_0000);
        p4 = z;
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("starve lsu_cnt c%0d", i), 64'(dut.lsu_cnt_reg), 64'(i));
            p = mk(6'(2 * i), 32'h7777_0000 + 32'(i));
            if (i % 2 == 0) drive(p, z, ls, z);
            else            drive(z, p, ls, z);
            if (i < 4) begin
                step($sformatf("starve c%0d", i), (i % 2 == 0) ? 4'b0001 : 4'b0010, ev(p), eh(ls5_dummy(ls)));
            end else begin
                p4 = p;
                step("starve c4", 4'b0100, ev(ls), eh(mk(6'd9, 32'h2222_0009)));
            end
        end
        chk("starve lsu_cnt c5", 64'(dut.lsu_cnt_reg), 64'(0));
        drive(p4, z, z, z);
        step("starve c5", 4'b0001, ev(p4), eh(mk(6'd9, 32'h2222_0009)));

        // Flush mid-stream
        a0pre = mk(6'd3, 32'h8888_0003);
        ls5   = mk(6'd5, 32'h9999_0005);
        drive(a0pre, z, ls5, z);
        step("pre-flush", 4'b0001, eh(p4), ev(a0pre));
        chk("pre-flush lsu_cnt", 64'(dut.lsu_cnt_reg), 64'(1));
        a0new = mk(6'd6, 32'hAAAA_0006);
        flush_i = 1'b1;
        drive(a0new, z, ls5, z);
        step("flush", 4'b0000, eh(p4), eh(a0pre));
        chk("flush lsu_cnt", 64'(dut.lsu_cnt_reg), 64'(0));
        flush_i = 1'b0;
        step("post-flush", 4'b0101, ev(a0new), ev(ls5));

        // Reset mid-operation: MDU starves behind ALU1 on bank 1
        md = mk(6'd1, 32'hBBBB_0001);
        for (int j = 0; j < 3; j++) begin
            a1j = mk(6'(2 * j + 3), 32'hCCCC_0000 + 32'(j));
            drive(z, a1j, z, md);
            step($sformatf("mdu starve c%0d", j), 4'b0010, eh(a0new), ev(a1j));
        end
        chk("pre-rst mdu_cnt", 64'(dut.mdu_cnt_reg), 64'(3));
        a1j = mk(6'd11, 32'hCCCC_0003);
        drive(z, a1j, z, md);
        rst = 1'b1; flush_i = 1'b1;
        step("rst+flush", 4'b0000, ev(z), ev(z));
        chk("rst mdu_cnt", 64'(dut.mdu_cnt_reg), 64'(0));
        flush_i = 1'b0;
        step("rst hold", 4'b0000, ev(z), ev(z));
        rst = 1'b0;
        drive(z, z, z, md);
        step("post-rst", 4'b1000, ev(z), ev(md));
        drive(z, z, z, z);
        step("final idle", 4'b0000, ev(z), eh(md));

        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    // Bank 1 during the starvation phase still holds the bank-split LSU payload.
    function automatic pipeline_cdb_t ls5_dummy(input pipeline_cdb_t unused_ls);
        pipeline_cdb_t r;
        r = unused_ls;
        r = mk(6'd9, 32'h2222_0009);
        return r;
    endfunction
endmodule
